// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and
// frame-length constants. Intended to be imported by both uart_tx and the
// future uart_rx so the two ends agree on framing.
package uart_tx_pkg;

   // 12 MHz system clock / 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 104;

   localparam int DATA_BITS      = 8;
   localparam int FRAME_BITS_8N1 = 10;
   localparam int FRAME_BITS_8E1 = 11;

   // PARITY is only visited when UART_TX_PARITY_EN is defined
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Total clock cycles occupied by one frame on the line
   function automatic int frame_cycles(input int clks_per_bit, input bit parity_en);
      return clks_per_bit * (parity_en ? FRAME_BITS_8E1 : FRAME_BITS_8N1);
   endfunction

   // Even parity: the parity bit makes the total count of ones even
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
// Pointers are AW bits and wrap modulo the depth; the occupancy count is
// AW+1 bits so that completely full and completely empty are distinct.
// A push while full is ignored and a pop while empty is ignored; the full
// and empty flags are derived from the registered count, so a push at an
// edge is judged against the occupancy before that edge even if a pop
// happens at the same edge.
module uart_tx_sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers CPU bytes in a small FIFO and shifts them out
// LSB first as 8N1 frames, or 8E1 frames when UART_TX_PARITY_EN is defined.
// is_transmitting reports a full FIFO and is the CPU's backpressure signal;
// a write attempted while it is high is dropped and latches overflow until
// reset. Consecutive queued bytes go out with no idle gap between frames.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_AW      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         tx_byte,
   input  logic               transmit,
   output logic               is_transmitting,
   output logic               tx,
   output logic               tx_busy,
   output logic               overflow,
   output logic [FIFO_AW:0]   fifo_count
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   state_t              state;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [2:0]          bit_idx;
   logic [7:0]          shreg;
   logic                bit_end;

   logic [7:0]          fifo_dout;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic [FIFO_AW:0]    fifo_level;

`ifdef UART_TX_PARITY_EN
   logic                parity_bit;
`endif

   uart_tx_sync_fifo #(
      .W  (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (transmit),
      .din   (tx_byte),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_level)
   );

   assign bit_end         = (baud_cnt == BAUD_LAST);
   assign is_transmitting = fifo_full;
   assign fifo_count      = fifo_level;

   // A byte leaves the FIFO when an idle line picks it up, or when a stop
   // bit finishes and the next frame follows immediately
   assign fifo_pop = !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && bit_end));

   // Drop-on-full flag that only reset clears
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (transmit && fifo_full) begin
         overflow <= 1'b1;
      end
   end

   // Frame sequencer: baud timing, bit counting, shifting and the line itself
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               tx       <= 1'b1;
               if (!fifo_empty) begin
                  shreg   <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= even_parity(fifo_dout);
`endif
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
                  state   <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  if (!fifo_empty) begin
                     shreg   <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                     parity_bit <= even_parity(fifo_dout);
`endif
                     tx      <= 1'b0;
                     state   <= START;
                  end else begin
                     tx      <= 1'b1;
                     tx_busy <= 1'b0;
                     state   <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               tx_busy  <= 1'b0;
               baud_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4 and FIFO_AW=2.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

   localparam int CPB = 4;
   localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
   localparam int SLOTS = 11;
`else
   localparam int SLOTS = 10;
`endif
   localparam int FRAME_CYC = SLOTS * CPB;
   localparam int HIST      = 8192;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    tx_byte = 8'h00;
   logic          transmit = 1'b0;
   logic          is_transmitting;
   logic          tx;
   logic          tx_busy;
   logic          overflow;
   logic [AW:0]   fifo_count;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic tx_hist   [HIST];
   logic busy_hist [HIST];

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (AW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .tx_byte         (tx_byte),
      .transmit        (transmit),
      .is_transmitting (is_transmitting),
      .tx              (tx),
      .tx_busy         (tx_busy),
      .overflow        (overflow),
      .fifo_count      (fifo_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Edge counter: cyc == N after posedge N
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Line recorder: hist[N] holds outputs as they stand after posedge N
   always @(negedge clk) begin
      if (cyc < HIST) begin
         tx_hist[cyc]   <= tx;
         busy_hist[cyc] <= tx_busy;
      end
   end

   // Runaway guard
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected line level for a given bit slot of a frame carrying b
   function automatic logic exp_bit(input logic [7:0] b, input int slot);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
      if (slot == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Strobe transmit for exactly one posedge; called and returns at a negedge
   task automatic write_byte(input logic [7:0] b);
      tx_byte  = b;
      transmit = 1'b1;
      @(negedge clk);
      transmit = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (is_transmitting !== 1'b0) begin failures++; $display("[TB] FAIL reset_is_tx: got %b expected 0", is_transmitting); end
      checks++; if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: got tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy); end
   endtask

   task automatic test_single_frame;
      int  n;
      int  bad;
      write_byte(8'h55);
      n = cyc;
      checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_at_write: got %b expected 1", tx); end
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL single_count_at_write: got %0d expected 1", fifo_count); end
      repeat (FRAME_CYC + 2) @(negedge clk);
      for (int s = 0; s < SLOTS; s++) begin
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (tx_hist[n+1+s*CPB+c] !== exp_bit(8'h55, s)) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("[TB] FAIL single_slot%0d: got %0d wrong cycles expected level %b for all %0d", s, bad, exp_bit(8'h55, s), CPB);
         end
      end
      bad = 0;
      for (int k = 0; k < FRAME_CYC; k++) begin
         if (busy_hist[n+1+k] !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("[TB] FAIL single_busy_len: got %0d low cycles expected 0", bad); end
      checks++; if (busy_hist[n+1+FRAME_CYC] !== 1'b0 || tx_hist[n+1+FRAME_CYC] !== 1'b1) begin
         failures++; $display("[TB] FAIL single_end: got busy=%b tx=%b expected busy=0 tx=1", busy_hist[n+1+FRAME_CYC], tx_hist[n+1+FRAME_CYC]);
      end
   endtask

   task automatic test_back_to_back;
      int         n;
      int         bad;
      logic [7:0] b;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tx_byte  = 8'hA1 + 8'(i);
         transmit = 1'b1;
         @(negedge clk);
         if (i == 0) n = cyc;
         if (i == 3) begin
            checks++; if (is_transmitting !== 1'b0 || fifo_count !== 3'd3) begin
               failures++; $display("[TB] FAIL b2b_after_4th: got is_tx=%b count=%0d expected is_tx=0 count=3", is_transmitting, fifo_count);
            end
         end
         if (i == 4) begin
            checks++; if (is_transmitting !== 1'b1 || fifo_count !== 3'd4) begin
               failures++; $display("[TB] FAIL b2b_full: got is_tx=%b count=%0d expected is_tx=1 count=4", is_transmitting, fifo_count);
            end
            checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_early_ovf: got %b expected 0", overflow); end
         end
      end
      transmit = 1'b0;
      checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL b2b_overflow: got %b expected 1", overflow); end
      checks++; if (fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL b2b_drop: got count=%0d expected 4", fifo_count); end
      repeat (5 * FRAME_CYC) @(negedge clk);
      for (int f = 0; f < 5; f++) begin
         b   = 8'hA1 + 8'(f);
         bad = 0;
         for (int k = 0; k < FRAME_CYC; k++) begin
            if (tx_hist[n+1+f*FRAME_CYC+k] !== exp_bit(b, k / CPB)) bad++;
            if (busy_hist[n+1+f*FRAME_CYC+k] !== 1'b1) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++; $display("[TB] FAIL b2b_frame%0d: got %0d bad cycles expected byte %h with busy high", f, bad, b);
         end
      end
      checks++; if (busy_hist[n+1+5*FRAME_CYC] !== 1'b0) begin
         failures++; $display("[TB] FAIL b2b_sixth_frame: got busy=%b expected 0", busy_hist[n+1+5*FRAME_CYC]);
      end
      checks++; if (fifo_count !== 3'd0 || is_transmitting !== 1'b0 || overflow !== 1'b1) begin
         failures++; $display("[TB] FAIL b2b_drained: got count=%0d is_tx=%b ovf=%b expected 0 0 1", fifo_count, is_transmitting, overflow);
      end
   endtask

   task automatic test_reset_mid_frame;
      int bad;
      write_byte(8'hFF);
      write_byte(8'h12);
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL midrst_queued: got %0d expected 1", fifo_count); end
      repeat (14) @(negedge clk);
      checks++; if (tx_busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", tx_busy); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_line: got tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy);
      end
      checks++; if (fifo_count !== 3'd0 || overflow !== 1'b0 || is_transmitting !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_state: got count=%0d ovf=%b is_tx=%b expected 0 0 0", fifo_count, overflow, is_transmitting);
      end
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 3 * FRAME_CYC; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("[TB] FAIL midrst_no_frame: got %0d active cycles expected 0", bad); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      int n;
      int bad;
      write_byte(8'h07);
      n = cyc;
      repeat (FRAME_CYC + 2) @(negedge clk);
      bad = 0;
      for (int c = 0; c < CPB; c++) if (tx_hist[n+1+9*CPB+c] !== 1'b1) bad++;
      checks++; if (bad != 0) begin failures++; $display("[TB] FAIL parity_07: got %0d low cycles expected parity 1", bad); end
      checks++; if (busy_hist[n+44] !== 1'b1 || busy_hist[n+45] !== 1'b0) begin
         failures++; $display("[TB] FAIL parity_len: got busy %b,%b expected 1,0", busy_hist[n+44], busy_hist[n+45]);
      end
      write_byte(8'h03);
      n = cyc;
      repeat (FRAME_CYC + 2) @(negedge clk);
      bad = 0;
      for (int c = 0; c < CPB; c++) if (tx_hist[n+1+9*CPB+c] !== 1'b0) bad++;
      checks++; if (bad != 0) begin failures++; $display("[TB] FAIL parity_03: got %0d high cycles expected parity 0", bad); end
   endtask
`endif

   task automatic test_echo;
      int         n;
      int         w;
      int         p;
      int         stop_c;
      logic [7:0] got;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         w = 0;
         while (is_transmitting === 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
         end
         if (w >= 500) begin
            checks++; failures++;
            $display("[TB] FAIL echo_poll%0d: got is_transmitting stuck high expected release", i);
            break;
         end
         write_byte(8'h30 + 8'(i));
         if (i == 0) n = cyc;
      end
      w = 0;
      while ((tx_busy !== 1'b0 || fifo_count !== 3'd0) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      checks++; if (w >= 2000) begin failures++; $display("[TB] FAIL echo_drain: got busy after %0d cycles expected idle", w); end
      repeat (2) @(negedge clk);
      stop_c = cyc - 1;
      p = n + 1;
      for (int f = 0; f < 10; f++) begin
         while (p < stop_c && tx_hist[p] === 1'b1) p++;
         if (p + FRAME_CYC > stop_c) begin
            checks++; failures++;
            $display("[TB] FAIL echo_frame%0d: got no frame expected byte %h", f, 8'h30 + 8'(f));
            break;
         end
         for (int i = 0; i < 8; i++) got[i] = tx_hist[p + CPB*(1+i) + CPB/2];
         checks++;
         if (got !== 8'h30 + 8'(f) || tx_hist[p + CPB/2] !== 1'b0 || tx_hist[p + FRAME_CYC - CPB/2] !== 1'b1) begin
            failures++; $display("[TB] FAIL echo_frame%0d: got %h expected %h with start 0 stop 1", f, got, 8'h30 + 8'(f));
         end
         p = p + FRAME_CYC;
      end
      checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL echo_overflow: got %b expected 0", overflow); end
   endtask

   // Scenario sequence
   initial begin
      $display("[TB] uart_tx bench start, frame %0d cycles", FRAME_CYC);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_echo();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
